// File: rtl/ov7670_dvp_tx_if.sv
// Pixel handshake and DVP bus between the transmitter and its neighbours.
// The transmitter uses the master modport; the pixel source and bus sink use slave.
interface ov7670_dvp_tx_if;
  logic [7:0] pix_r;
  logic [7:0] pix_g;
  logic [7:0] pix_b;
  logic       pix_ack;
  logic       pclk;
  logic       vsync;
  logic       href;
  logic [7:0] d;

  modport master (
    input  pix_r, pix_g, pix_b,
    output pix_ack, pclk, vsync, href, d
  );

  modport slave (
    output pix_r, pix_g, pix_b,
    input  pix_ack, pclk, vsync, href, d
  );
endinterface

// File: rtl/ov7670_dvp_tx.sv
// OV7670-style DVP transmitter: RGB888 in via one-cycle ack, RGB565 byte pairs out
// with VGA-like frame timing on pclk = clk/2.
module ov7670_dvp_tx #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 784,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 17,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 510
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  ov7670_dvp_tx_if.master       bus,
  output logic                  frame_start,
  output logic                  frame_done
);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

  localparam logic [11:0] BC_LAST   = 12'(2*H_TOTAL - 1);
  localparam logic [11:0] BC_ACT    = 12'(2*H_ACTIVE);
  localparam logic [9:0]  LC_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VBP_START = 10'(V_SYNC);
  localparam logic [9:0]  ACT_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  VFP_START = 10'(V_SYNC + V_BP + V_ACTIVE);

  state_t      state, state_nxt;
  logic        ph;
  logic [11:0] bc, bc_nxt;
  logic [9:0]  lc, lc_nxt;
  logic        line_end, frame_end;
  logic        start_nxt, done_nxt, href_nxt;
  logic        ack_q, vsync_q, href_q;
  logic [7:0]  d_q;
  logic [15:0] hold;
  logic [15:0] pix565;

  function automatic state_t line_state(input logic [9:0] l);
    if (l < VBP_START)      return VSYNC;
    else if (l < ACT_START) return VBP;
    else if (l < VFP_START) return ACTIVE;
    else                    return VFP;
  endfunction

  assign pix565 = {bus.pix_r[7:3], bus.pix_g[7:2], bus.pix_b[7:3]};

  // Next bus position; committed on ph 1->0, peeked on ph 0->1 to schedule the ack.
  always_comb begin
    line_end  = (bc == BC_LAST);
    frame_end = line_end && (lc == LC_LAST);
    bc_nxt    = bc;
    lc_nxt    = lc;
    state_nxt = state;
    start_nxt = 1'b0;
    done_nxt  = 1'b0;
    if (state == IDLE) begin
      bc_nxt = '0;
      lc_nxt = '0;
      if (enable) begin
        state_nxt = VSYNC;
        start_nxt = 1'b1;
      end
    end else begin
      bc_nxt = line_end ? 12'd0 : bc + 12'd1;
      if (line_end) lc_nxt = frame_end ? 10'd0 : lc + 10'd1;
      state_nxt = line_state(lc_nxt);
      if (frame_end) begin
        done_nxt = 1'b1;
        if (enable) start_nxt = 1'b1;
        else        state_nxt = IDLE;
      end
    end
    href_nxt = (state_nxt == ACTIVE) && (bc_nxt < BC_ACT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ph          <= 1'b0;
      bc          <= '0;
      lc          <= '0;
      ack_q       <= 1'b0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      d_q         <= '0;
      hold        <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      ph          <= ~ph;
      ack_q       <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      if (!ph) begin
        ack_q <= href_nxt && !bc_nxt[0];
      end else begin
        state       <= state_nxt;
        bc          <= bc_nxt;
        lc          <= lc_nxt;
        frame_start <= start_nxt;
        frame_done  <= done_nxt;
        vsync_q     <= (state_nxt == VSYNC);
        href_q      <= href_nxt;
        if (!href_nxt) begin
          d_q <= '0;
        end else if (!bc_nxt[0]) begin
          hold <= pix565;
          d_q  <= pix565[15:8];
        end else begin
          d_q <= hold[7:0];
        end
      end
    end
  end

  assign bus.pclk    = ph;
  assign bus.pix_ack = ack_q;
  assign bus.vsync   = vsync_q;
  assign bus.href    = href_q;
  assign bus.d       = d_q;

endmodule
